// File: rtl/mac_lookup_sched.sv
`default_nettype none
// ============================================================================
// Module   : mac_lookup_sched
// Purpose  : Round-robin scheduler sharing one MAC lookup/learning table among
//            REQS ingress requesters. One lookup in flight at a time. The
//            table result is captured, turned into a filtered forwarding mask
//            and returned to the issuing requester. Hit/miss statistics are
//            also kept here.
// Ports    : clk, reset             - clock, async active-high reset
//            req_valid/ready        - per-requester request handshake
//            req_dst/src/port       - packed per-requester lookup fields
//            tbl_*                  - MAC table drive (out) and result (in)
//            rsp_valid/ready        - per-requester response handshake
//            rsp_found/port/mask    - registered lookup result
//            busy                   - scheduler not idle
//            hit_count/miss_count   - wrapping completion statistics
// Revision : 1.0 - initial release
// ============================================================================
module mac_lookup_sched #(
  parameter int ADDR_WIDTH = 48,
  parameter int REQS       = 4,
  parameter int PORTS      = 16,
  parameter int TBL_LAT    = 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [REQS-1:0]            req_valid,
  output logic [REQS-1:0]            req_ready,
  input  logic [REQS*ADDR_WIDTH-1:0] req_dst,
  input  logic [REQS*ADDR_WIDTH-1:0] req_src,
  input  logic [REQS*4-1:0]          req_port,
  output logic [ADDR_WIDTH-1:0]      tbl_mac_addr,
  output logic [ADDR_WIDTH-1:0]      tbl_src_addr,
  output logic [3:0]                 tbl_incoming_port,
  input  logic [3:0]                 tbl_port_out,
  input  logic                       tbl_found,
  input  logic [PORTS-1:0]           tbl_broadcast,
  output logic [REQS-1:0]            rsp_valid,
  input  logic [REQS-1:0]            rsp_ready,
  output logic                       rsp_found,
  output logic [3:0]                 rsp_port,
  output logic [PORTS-1:0]           rsp_mask,
  output logic                       busy,
  output logic [15:0]                hit_count,
  output logic [15:0]                miss_count
);

  localparam int c_IDX_W = (REQS > 1) ? $clog2(REQS) : 1;
  localparam int c_CNT_W = $clog2(TBL_LAT + 2);
  localparam logic [c_CNT_W-1:0] c_LAT_LAST = c_CNT_W'(TBL_LAT);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_LOOKUP  = 2'd1,
    ST_RESPOND = 2'd2
  } state_t;

  state_t r_state, w_state_next;

  logic [c_IDX_W-1:0]    r_rr_ptr;
  logic [c_IDX_W-1:0]    r_gnt;
  logic [c_CNT_W-1:0]    r_lat_cnt;
  logic [ADDR_WIDTH-1:0] r_dst;
  logic [ADDR_WIDTH-1:0] r_src;
  logic [3:0]            r_port;
  logic [REQS-1:0]       r_rsp_valid;
  logic                  r_rsp_found;
  logic [3:0]            r_rsp_port;
  logic [PORTS-1:0]      r_rsp_mask;
  logic [15:0]           r_hit_count;
  logic [15:0]           r_miss_count;

  logic                  w_any;
  logic [c_IDX_W-1:0]    w_gnt_idx;
  logic                  w_grant;
  logic                  w_capture;
  logic                  w_accept;
  logic [ADDR_WIDTH-1:0] w_sel_dst;
  logic [ADDR_WIDTH-1:0] w_sel_src;
  logic [3:0]            w_sel_port;
  logic [REQS-1:0]       w_gnt_onehot;
  logic [PORTS-1:0]      w_hit_onehot;
  logic [PORTS-1:0]      w_ingress_bit;
  logic [PORTS-1:0]      w_mask;

  // Rotating priority search: first requester at or above r_rr_ptr, wrapping.
  always_comb begin
    logic [c_IDX_W-1:0] v_cand;
    int                 v_k;
    w_any     = 1'b0;
    w_gnt_idx = '0;
    v_cand    = '0;
    v_k       = 0;
    for (int i = 0; i < REQS; i++) begin
      v_k    = (int'(r_rr_ptr) + i) % REQS;
      v_cand = c_IDX_W'(v_k);
      if (!w_any && req_valid[v_cand]) begin
        w_any     = 1'b1;
        w_gnt_idx = v_cand;
      end
    end
  end

  // Field mux for the winning requester (constant slice indices only).
  always_comb begin
    w_sel_dst  = '0;
    w_sel_src  = '0;
    w_sel_port = '0;
    for (int r = 0; r < REQS; r++) begin
      if (w_gnt_idx == c_IDX_W'(r)) begin
        w_sel_dst  = req_dst[r*ADDR_WIDTH +: ADDR_WIDTH];
        w_sel_src  = req_src[r*ADDR_WIDTH +: ADDR_WIDTH];
        w_sel_port = req_port[r*4 +: 4];
      end
    end
  end

  always_comb begin
    w_gnt_onehot        = '0;
    w_gnt_onehot[r_gnt] = 1'b1;
  end

  // A table port outside 0..PORTS-1 matches no bit, so the hit mask is zero.
  always_comb begin
    w_hit_onehot  = '0;
    w_ingress_bit = '0;
    for (int b = 0; b < PORTS; b++) begin
      w_hit_onehot[b]  = (tbl_port_out == 4'(b));
      w_ingress_bit[b] = (r_port == 4'(b));
    end
    if (tbl_found) begin
      w_mask = (tbl_port_out == r_port) ? '0 : w_hit_onehot;
    end else begin
      w_mask = tbl_broadcast & ~w_ingress_bit;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    req_ready    = '0;
    w_grant      = 1'b0;
    w_capture    = 1'b0;
    w_accept     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        // Gated by reset so that every output reads zero while reset is held.
        if (w_any && !reset) begin
          req_ready[w_gnt_idx] = 1'b1;
          w_grant              = 1'b1;
          w_state_next         = ST_LOOKUP;
        end
      end
      ST_LOOKUP: begin
        if (r_lat_cnt == c_LAT_LAST) begin
          w_capture    = 1'b1;
          w_state_next = ST_RESPOND;
        end
      end
      ST_RESPOND: begin
        if (rsp_ready[r_gnt]) begin
          w_accept     = 1'b1;
          w_state_next = ST_IDLE;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rr_ptr     <= '0;
      r_gnt        <= '0;
      r_lat_cnt    <= '0;
      r_dst        <= '0;
      r_src        <= '0;
      r_port       <= '0;
      r_rsp_valid  <= '0;
      r_rsp_found  <= 1'b0;
      r_rsp_port   <= '0;
      r_rsp_mask   <= '0;
      r_hit_count  <= '0;
      r_miss_count <= '0;
    end else begin
      if (w_grant) begin
        r_gnt     <= w_gnt_idx;
        r_dst     <= w_sel_dst;
        r_src     <= w_sel_src;
        r_port    <= w_sel_port;
        r_lat_cnt <= '0;
      end
      if (r_state == ST_LOOKUP) begin
        r_lat_cnt <= w_capture ? '0 : r_lat_cnt + 1'b1;
      end
      if (w_capture) begin
        r_rsp_valid <= w_gnt_onehot;
        r_rsp_found <= tbl_found;
        r_rsp_port  <= tbl_found ? tbl_port_out : 4'd0;
        r_rsp_mask  <= w_mask;
      end
      if (w_accept) begin
        r_rsp_valid <= '0;
        r_rr_ptr    <= (r_gnt == c_IDX_W'(REQS - 1)) ? '0 : r_gnt + 1'b1;
        if (r_rsp_found) begin
          r_hit_count <= r_hit_count + 16'd1;
        end else begin
          r_miss_count <= r_miss_count + 16'd1;
        end
      end
    end
  end

  // Zero table drive outside LOOKUP: a zero address matches only empty
  // entries, so the table neither learns nor reports a spurious hit.
  assign tbl_mac_addr      = (r_state == ST_LOOKUP) ? r_dst  : '0;
  assign tbl_src_addr      = (r_state == ST_LOOKUP) ? r_src  : '0;
  assign tbl_incoming_port = (r_state == ST_LOOKUP) ? r_port : '0;

  assign rsp_valid  = r_rsp_valid;
  assign rsp_found  = r_rsp_found;
  assign rsp_port   = r_rsp_port;
  assign rsp_mask   = r_rsp_mask;
  assign busy       = (r_state != ST_IDLE);
  assign hit_count  = r_hit_count;
  assign miss_count = r_miss_count;

endmodule
`default_nettype wire

// File: tb/tb_mac_lookup_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_mac_lookup_sched
// Purpose  : Self-checking bench for mac_lookup_sched with a behavioural
//            learning MAC table (registered output, one cycle latency).
// Revision : 1.0 - initial release
// ============================================================================
module tb_mac_lookup_sched;

  localparam int AW = 48;
  localparam int NR = 4;
  localparam int NP = 16;

  logic           clk = 1'b0;
  logic           reset;
  logic [NR-1:0]  req_valid;
  logic [NR-1:0]  req_ready;
  logic [NR*AW-1:0] req_dst;
  logic [NR*AW-1:0] req_src;
  logic [NR*4-1:0]  req_port;
  logic [AW-1:0]  tbl_mac_addr;
  logic [AW-1:0]  tbl_src_addr;
  logic [3:0]     tbl_incoming_port;
  logic [3:0]     tbl_port_out;
  logic           tbl_found;
  logic [NP-1:0]  tbl_broadcast;
  logic [NR-1:0]  rsp_valid;
  logic [NR-1:0]  rsp_ready;
  logic           rsp_found;
  logic [3:0]     rsp_port;
  logic [NP-1:0]  rsp_mask;
  logic           busy;
  logic [15:0]    hit_count;
  logic [15:0]    miss_count;

  mac_lookup_sched #(.ADDR_WIDTH(AW), .REQS(NR), .PORTS(NP), .TBL_LAT(1)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_dst(req_dst), .req_src(req_src), .req_port(req_port),
    .tbl_mac_addr(tbl_mac_addr), .tbl_src_addr(tbl_src_addr),
    .tbl_incoming_port(tbl_incoming_port),
    .tbl_port_out(tbl_port_out), .tbl_found(tbl_found),
    .tbl_broadcast(tbl_broadcast),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_found(rsp_found), .rsp_port(rsp_port), .rsp_mask(rsp_mask),
    .busy(busy), .hit_count(hit_count), .miss_count(miss_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- behavioural MAC table ----------------
  logic [AW-1:0] lt_mac  [8];
  logic [3:0]    lt_port [8];
  logic          lt_v    [8];

  function automatic int find_slot(input logic [AW-1:0] mac);
    int s;
    s = -1;
    for (int i = 0; i < 8; i++) if (s < 0 && lt_v[i] && lt_mac[i] == mac) s = i;
    for (int i = 0; i < 8; i++) if (s < 0 && !lt_v[i]) s = i;
    if (s < 0) s = 0;
    return s;
  endfunction

  function automatic logic lt_hit(input logic [AW-1:0] mac);
    logic h;
    h = 1'b0;
    for (int i = 0; i < 8; i++) if (mac != 0 && lt_v[i] && lt_mac[i] == mac) h = 1'b1;
    return h;
  endfunction

  function automatic logic [3:0] lt_get(input logic [AW-1:0] mac);
    logic [3:0] p;
    p = 4'd0;
    for (int i = 0; i < 8; i++) if (mac != 0 && lt_v[i] && lt_mac[i] == mac) p = lt_port[i];
    return p;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 8; i++) lt_v[i] <= 1'b0;
      tbl_found    <= 1'b0;
      tbl_port_out <= 4'd0;
    end else begin
      tbl_found    <= lt_hit(tbl_mac_addr);
      tbl_port_out <= lt_get(tbl_mac_addr);
      if (tbl_src_addr != 0) begin
        lt_v[find_slot(tbl_src_addr)]    <= 1'b1;
        lt_mac[find_slot(tbl_src_addr)]  <= tbl_src_addr;
        lt_port[find_slot(tbl_src_addr)] <= tbl_incoming_port;
      end
    end
  end

  // ---------------- checking ----------------
  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    int          r;
    logic [AW-1:0] dst;
    logic [AW-1:0] src;
    logic [3:0]  port;
    logic [15:0] bc;
    logic        found;
    logic [3:0]  eport;
    logic [15:0] mask;
  } vec_t;

  typedef struct {
    int          r;
    logic        found;
    logic [3:0]  port;
    logic [15:0] mask;
  } exp_t;

  vec_t vecs[9];
  exp_t sb[$];

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    req_valid = '0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Present one request; returns at the negedge after the grant edge with
  // req_valid dropped and fields scrambled.
  task automatic issue(input int r, input logic [AW-1:0] dst, input logic [AW-1:0] src,
                       input logic [3:0] port, input logic [15:0] bc, output int gcyc);
    int n;
    @(negedge clk);
    req_valid = '0;
    req_valid[r] = 1'b1;
    req_dst[r*AW +: AW] = dst;
    req_src[r*AW +: AW] = src;
    req_port[r*4 +: 4]  = port;
    tbl_broadcast = bc;
    #1;
    n = 0;
    while (req_ready == 0 && n < 20) begin
      @(negedge clk); #1; n++;
    end
    chk("grant", 64'(req_ready), 64'(4'b0001 << r));
    gcyc = cyc;
    @(negedge clk);
    req_valid = '0;
    req_dst[r*AW +: AW] = {$urandom, $urandom};
    req_src[r*AW +: AW] = {$urandom, $urandom};
    req_port[r*4 +: 4]  = 4'($urandom);
  endtask

  task automatic wait_rsp(output int rcyc);
    int n;
    #1;
    n = 0;
    while (rsp_valid == 0 && n < 20) begin
      @(negedge clk); #1; n++;
    end
    if (n >= 20) chk("rsp_timeout", 64'(rsp_valid), 64'd1);
    rcyc = cyc;
  endtask

  initial begin
    int gcyc, rcyc, nhit, nmiss, ngr;
    int gidx[5];
    int gcy[5];
    exp_t e;

    reset = 1'b1;
    req_valid = '0;
    req_dst = '0;
    req_src = '0;
    req_port = '0;
    rsp_ready = '0;
    tbl_broadcast = 16'hFFFF;
    nhit = 0;
    nmiss = 0;

    // Reset values
    repeat (2) @(negedge clk);
    #1;
    chk("reset_ctrl", {busy, req_ready, rsp_valid, rsp_found, rsp_port}, 64'd0);
    chk("reset_mask", 64'(rsp_mask), 64'd0);
    chk("reset_cnt", {hit_count, miss_count}, 64'd0);
    chk("reset_tbl", 64'(tbl_mac_addr | tbl_src_addr | AW'(tbl_incoming_port)), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    rsp_ready = 4'hF;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      chk("idle_quiet", {tbl_mac_addr, tbl_incoming_port, req_ready, busy}, 64'd0);
    end

    // Vector table: learning builds up across entries (BB..02 on port 3,
    // CC..03 on 5, DD..04 on 3, EE..05 on 0).
    vecs[0] = '{0, 48'hAA00_0000_0001, 48'hBB00_0000_0002, 4'd3,  16'hFFFF, 1'b0, 4'd0, 16'hFFF7};
    vecs[1] = '{1, 48'hBB00_0000_0002, 48'hCC00_0000_0003, 4'd5,  16'hFFFF, 1'b1, 4'd3, 16'h0008};
    vecs[2] = '{2, 48'hBB00_0000_0002, 48'hDD00_0000_0004, 4'd3,  16'hFFFF, 1'b1, 4'd3, 16'h0000};
    vecs[3] = '{3, 48'hCC00_0000_0003, 48'hEE00_0000_0005, 4'd0,  16'hFFFF, 1'b1, 4'd5, 16'h0020};
    vecs[4] = '{0, 48'h1111_1111_1111, 48'h0,              4'd7,  16'h00F0, 1'b0, 4'd0, 16'h0070};
    vecs[5] = '{1, 48'hEE00_0000_0005, 48'h0,              4'd15, 16'hFFFF, 1'b1, 4'd0, 16'h0001};
    vecs[6] = '{2, 48'h2222_2222_2222, 48'h0,              4'd15, 16'hFFFF, 1'b0, 4'd0, 16'h7FFF};
    vecs[7] = '{3, 48'h3333_3333_3333, 48'h0,              4'd0,  16'h0001, 1'b0, 4'd0, 16'h0000};
    vecs[8] = '{0, 48'hDD00_0000_0004, 48'h0,              4'd3,  16'hFFFF, 1'b1, 4'd3, 16'h0000};

    for (int i = 0; i < 9; i++) begin
      issue(vecs[i].r, vecs[i].dst, vecs[i].src, vecs[i].port, vecs[i].bc, gcyc);
      sb.push_back('{vecs[i].r, vecs[i].found, vecs[i].eport, vecs[i].mask});
      wait_rsp(rcyc);
      chk("rsp_latency", 64'(rcyc - gcyc), 64'd3);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("rsp_valid", 64'(rsp_valid), 64'(4'b0001 << e.r));
        chk("rsp_found", 64'(rsp_found), 64'(e.found));
        chk("rsp_port",  64'(rsp_port),  64'(e.port));
        chk("rsp_mask",  64'(rsp_mask),  64'(e.mask));
        if (e.found) nhit++; else nmiss++;
      end
      @(negedge clk); #1;
      chk("counters", {hit_count, miss_count}, {16'(nhit), 16'(nmiss)});
      chk("idle_after", 64'(busy), 64'd0);
    end

    // Round robin with all requesters pending and responses always taken.
    // Grant at T, response at T+3 accepted, IDLE and next grant at T+4.
    do_reset();
    req_dst = '0;
    req_src = '0;
    rsp_ready = 4'hF;
    req_valid = 4'hF;
    ngr = 0;
    for (int c = 0; c < 40; c++) begin
      #1;
      if (req_ready != 0 && ngr < 5) begin
        gidx[ngr] = 0;
        for (int b = 0; b < NR; b++) if (req_ready[b]) gidx[ngr] = b;
        gcy[ngr] = cyc;
        ngr++;
      end
      @(negedge clk);
    end
    req_valid = '0;
    chk("rr_count", 64'(ngr), 64'd5);
    for (int k = 0; k < 5; k++) begin
      if (k < ngr) begin
        chk("rr_order", 64'(gidx[k]), 64'(k % 4));
        if (k > 0) chk("rr_spacing", 64'(gcy[k] - gcy[k-1]), 64'd4);
      end
    end
    repeat (6) @(negedge clk);

    // Backpressure: other requesters' rsp_ready must be ignored.
    do_reset();
    rsp_ready = 4'b1110;
    issue(0, 48'h0000_0000_0123, 48'h0, 4'd2, 16'hFFFF, gcyc);
    req_valid = 4'b0010;
    wait_rsp(rcyc);
    for (int c = 0; c < 10; c++) begin
      chk("bp_hold", {rsp_valid, rsp_found, rsp_port, rsp_mask, busy, req_ready},
          {4'b0001, 1'b0, 4'd0, 16'hFFFB, 1'b1, 4'b0000});
      @(negedge clk); #1;
    end
    rsp_ready = 4'b0001;
    @(negedge clk); #1;
    chk("bp_release_grant", 64'(req_ready), 64'b0010);
    chk("bp_release_cnt", 64'(miss_count), 64'd1);
    req_valid = '0;
    rsp_ready = 4'hF;
    repeat (6) @(negedge clk);

    // Reset in the second LOOKUP cycle with counters already non-zero.
    issue(1, 48'h0000_0000_0456, 48'h0, 4'd1, 16'hFFFF, gcyc);
    req_valid = 4'b0100;
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("midrst_out", {busy, rsp_valid, req_ready, hit_count, miss_count}, 64'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("midrst_regrant", 64'(req_ready), 64'b0100);
    @(negedge clk);
    req_valid = '0;
    wait_rsp(rcyc);
    chk("midrst_rsp", 64'(rsp_valid), 64'b0100);
    repeat (3) @(negedge clk);

    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
